// File: rtl/alu_result_stage_if.sv
// Handshake and data bundle between the ALU, the result stage and writeback.
// master drives the upstream entry and downstream ready; slave is the stage itself.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

interface alu_result_stage_if #(
    parameter int unsigned WIDTH = `WORD_LENGTH,
    parameter int unsigned RIDX  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [0:WIDTH-1] in_r;
    logic             in_c;
    logic             in_n;
    logic             in_z;
    logic [0:2]       in_cond;
    logic [0:1]       in_mode;
    logic [0:RIDX-1]  in_rd;
    logic             in_wen;
    logic             out_valid;
    logic             out_ready;
    logic [0:WIDTH-1] out_r;
    logic [0:RIDX-1]  out_rd;
    logic             out_wen;
    logic             out_cond;
    logic             out_c;

    modport master (
        output in_valid, in_r, in_c, in_n, in_z, in_cond, in_mode, in_rd, in_wen, out_ready,
        input  in_ready, out_valid, out_r, out_rd, out_wen, out_cond, out_c
    );

    modport slave (
        input  in_valid, in_r, in_c, in_n, in_z, in_cond, in_mode, in_rd, in_wen, out_ready,
        output in_ready, out_valid, out_r, out_rd, out_wen, out_cond, out_c
    );
endinterface

// File: rtl/alu_result_stage.sv
// Execute-stage output register: evaluates the branch/compare condition on the ALU flags,
// forms the writeback entry at accept time and holds it in a two-entry skid buffer.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module alu_result_stage #(
    parameter int unsigned WIDTH = `WORD_LENGTH,
    parameter int unsigned RIDX  = 4
) (
    input logic               clk,
    input logic               rst,
    input logic               flush,
    alu_result_stage_if.slave bus
);
    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    typedef struct packed {
        logic [0:WIDTH-1] r;
        logic [0:RIDX-1]  rd;
        logic             wen;
        logic             cond;
        logic             c;
    } entry_t;

    state_e state_q, state_d;
    entry_t m_q, m_d;
    entry_t s_q, s_d;
    entry_t new_entry;
    logic   cv;
    logic   acc;
    logic   dq;

    // Condition evaluation and result forming happen once, at accept.
    always_comb begin
        cv = 1'b0;
        case (bus.in_cond)
            3'd0:    cv = bus.in_z;
            3'd1:    cv = bus.in_n;
            3'd2:    cv = ~bus.in_z;
            3'd3:    cv = bus.in_n | bus.in_z;
            3'd4:    cv = ~bus.in_n & ~bus.in_z;
            3'd5:    cv = ~bus.in_n;
            3'd6:    cv = bus.in_c;
            default: cv = ~bus.in_c;
        endcase

        new_entry = '{r: bus.in_r, rd: bus.in_rd, wen: bus.in_wen, cond: cv, c: bus.in_c};
        unique case (bus.in_mode)
            2'b01: begin
                new_entry.r          = '0;
                new_entry.r[WIDTH-1] = cv;
            end
            2'b10:   new_entry.wen = bus.in_wen & cv;
            default: ;
        endcase
    end

    // Ready depends only on registered state, so out_ready never reaches in_ready.
    assign bus.in_ready  = ~rst & (state_q != StTwo);
    assign bus.out_valid = ~rst & (state_q != StEmpty);
    assign acc           = bus.in_valid & bus.in_ready;
    assign dq            = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            StEmpty: begin
                if (acc) begin
                    state_d = StOne;
                    m_d     = new_entry;
                end
            end
            StOne: begin
                if (acc && dq) begin
                    m_d = new_entry;
                end else if (acc) begin
                    state_d = StTwo;
                    s_d     = new_entry;
                end else if (dq) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (dq) begin
                    state_d = StOne;
                    m_d     = s_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        // A same-cycle dequeue still completes; everything else is dropped.
        if (flush) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
        m_q <= m_d;
        s_q <= s_d;
    end

    assign bus.out_r    = bus.out_valid ? m_q.r    : '0;
    assign bus.out_rd   = bus.out_valid ? m_q.rd   : '0;
    assign bus.out_wen  = bus.out_valid & m_q.wen;
    assign bus.out_cond = bus.out_valid & m_q.cond;
    assign bus.out_c    = bus.out_valid & m_q.c;
endmodule
